// File: rtl/cvo_vga_out.sv
// cvo_vga_out: CVO clocked-video bus to DE1-SoC ADV7123 VGA DAC pins.
// Two-stage registered path: stage 1 captures inputs, stage 2 picks the colour.
// Ports: clk_clk, reset_reset (sync, active-high); vid_* CVO inputs; test_en;
//   vga_r/g/b, vga_hs/vs, vga_blank_n, vga_sync_n, vga_clk DAC pins;
//   frame_cnt, underflow_cnt, line_len, frame_lines, fill_active status.
module cvo_vga_out #(
    parameter logic        HS_ACTIVE_LOW = 1'b1,
    parameter logic        VS_ACTIVE_LOW = 1'b1,
    parameter logic [23:0] FILL_RGB      = 24'h0000FF,
    parameter int          BAR_WIDTH     = 80
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [31:0] vid_data,
    input  logic        vid_datavalid,
    input  logic        vid_h_sync,
    input  logic        vid_v_sync,
    input  logic        vid_underflow,
    input  logic        test_en,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        vga_clk,
    output logic [15:0] frame_cnt,
    output logic [15:0] underflow_cnt,
    output logic [11:0] line_len,
    output logic [10:0] frame_lines,
    output logic        fill_active
);

    localparam logic [8:0] BW = 9'(BAR_WIDTH);

    // Stage 1 captures
    logic [23:0] rgb_in_q;
    logic        dv_q, hs_q, vs_q, uf_q, te_q;
    // Previous stage-1 values for edge detection
    logic        dv_h_q, vs_h_q, uf_h_q;
    // s1_vld_q: stage 1 holds a real sample, not reset contents.
    // armed_q: a genuine inactive cycle has been seen since reset, so a
    // following line is complete and may be latched.
    logic        s1_vld_q, armed_q;

    // Stage 2 state
    logic [23:0] rgb_q, rgb_d;
    logic        blank_q, hs_o_q, vs_o_q;
    logic [15:0] fcnt_q, fcnt_d, ucnt_q, ucnt_d;
    logic [11:0] len_q, len_d, pix_q, pix_d;
    logic [10:0] flines_q, flines_d, lines_q, lines_d;
    logic        fill_q, fill_d;
    logic [2:0]  bar_q, bar_d, bar_cur;
    logic [8:0]  left_q, left_d, left_cur;

    logic line_start, line_end, fs, uf_rise;
    logic unused_hi;

    assign unused_hi  = ^vid_data[31:24];
    assign line_start = dv_q & ~dv_h_q;
    assign line_end   = dv_h_q & ~dv_q & armed_q;
    assign fs         = vs_q & ~vs_h_q;
    assign uf_rise    = uf_q & ~uf_h_q;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rgb_in_q <= '0;
            dv_q     <= 1'b0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            uf_q     <= 1'b0;
            te_q     <= 1'b0;
            dv_h_q   <= 1'b0;
            vs_h_q   <= 1'b0;
            uf_h_q   <= 1'b0;
            s1_vld_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            rgb_in_q <= vid_data[23:0];
            dv_q     <= vid_datavalid;
            hs_q     <= vid_h_sync;
            vs_q     <= vid_v_sync;
            uf_q     <= vid_underflow;
            te_q     <= test_en;
            dv_h_q   <= dv_q;
            vs_h_q   <= vs_q;
            uf_h_q   <= uf_q;
            s1_vld_q <= 1'b1;
            armed_q  <= armed_q | (s1_vld_q & ~dv_q);
        end
    end

    // Bar tracking: left_q counts pixels still to go in the current bar.
    // It runs whenever pixels are valid so the bar follows true pixel x.
    always_comb begin
        bar_cur  = line_start ? 3'd0 : bar_q;
        left_cur = line_start ? BW : left_q;
        bar_d    = bar_q;
        left_d   = left_q;
        if (dv_q) begin
            if (left_cur == 9'd1) begin
                left_d = BW;
                bar_d  = (bar_cur == 3'd7) ? 3'd7 : bar_cur + 3'd1;
            end else begin
                left_d = left_cur - 9'd1;
                bar_d  = bar_cur;
            end
        end
    end

    always_comb begin
        pix_d = pix_q;
        if (dv_q) begin
            if (line_start)
                pix_d = 12'd1;
            else if (pix_q != 12'hFFF)
                pix_d = pix_q + 12'd1;
        end
        len_d = line_end ? pix_q : len_q;
        lines_d  = lines_q;
        flines_d = flines_q;
        fcnt_d   = fcnt_q;
        if (fs) begin
            flines_d = lines_q;
            lines_d  = 11'd0;
            fcnt_d   = fcnt_q + 16'd1;
        end else if (line_end && lines_q != 11'h7FF) begin
            lines_d = lines_q + 11'd1;
        end
        ucnt_d = ucnt_q;
        if (uf_rise && ucnt_q != 16'hFFFF)
            ucnt_d = ucnt_q + 16'd1;
        // A new underflow edge beats the frame-start clear.
        fill_d = uf_rise ? 1'b1 : (fs ? 1'b0 : fill_q);
    end

    // Uses fill_d so the pixel that arrives with the edge is already filled.
    always_comb begin
        rgb_d = rgb_in_q;
        if (!dv_q)
            rgb_d = 24'h0;
        else if (fill_d)
            rgb_d = FILL_RGB;
        else if (te_q)
            rgb_d = {{8{~bar_cur[1]}}, {8{~bar_cur[2]}}, {8{~bar_cur[0]}}};
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rgb_q    <= '0;
            blank_q  <= 1'b0;
            hs_o_q   <= HS_ACTIVE_LOW;
            vs_o_q   <= VS_ACTIVE_LOW;
            fcnt_q   <= '0;
            ucnt_q   <= '0;
            len_q    <= '0;
            pix_q    <= '0;
            flines_q <= '0;
            lines_q  <= '0;
            fill_q   <= 1'b0;
            bar_q    <= '0;
            left_q   <= '0;
        end else begin
            rgb_q    <= rgb_d;
            blank_q  <= dv_q;
            hs_o_q   <= hs_q ^ HS_ACTIVE_LOW;
            vs_o_q   <= vs_q ^ VS_ACTIVE_LOW;
            fcnt_q   <= fcnt_d;
            ucnt_q   <= ucnt_d;
            len_q    <= len_d;
            pix_q    <= pix_d;
            flines_q <= flines_d;
            lines_q  <= lines_d;
            fill_q   <= fill_d;
            bar_q    <= bar_d;
            left_q   <= left_d;
        end
    end

    assign vga_r         = rgb_q[23:16];
    assign vga_g         = rgb_q[15:8];
    assign vga_b         = rgb_q[7:0];
    assign vga_hs        = hs_o_q;
    assign vga_vs        = vs_o_q;
    assign vga_blank_n   = blank_q;
    assign vga_sync_n    = 1'b0;
    assign vga_clk       = clk_clk;
    assign frame_cnt     = fcnt_q;
    assign underflow_cnt = ucnt_q;
    assign line_len      = len_q;
    assign frame_lines   = flines_q;
    assign fill_active   = fill_q;

endmodule

// File: tb/tb_cvo_vga_out.sv
// tb_cvo_vga_out: self-checking bench for cvo_vga_out with a cycle-level
// reference model, constant vector tables and directed corner sequences.
module tb_cvo_vga_out;

    localparam int          BW   = 80;
    localparam logic [23:0] FILL = 24'h0000FF;

    typedef struct packed {
        logic        dv;
        logic        hs;
        logic        vs;
        logic        uf;
        logic        te;
        logic [31:0] d;
    } vin_t;

    typedef struct {
        int          w;
        bit          te;
        logic [31:0] d;
        logic [11:0] exp_len;
        logic [23:0] exp_px0;
    } line_vec_t;

    typedef struct {
        int          x;
        logic [23:0] rgb;
    } bar_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    vin_t cur = '0;

    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;
    logic [15:0] frame_cnt, underflow_cnt;
    logic [11:0] line_len;
    logic [10:0] frame_lines;
    logic        fill_active;

    cvo_vga_out dut (
        .clk_clk      (clk),
        .reset_reset  (rst),
        .vid_data     (cur.d),
        .vid_datavalid(cur.dv),
        .vid_h_sync   (cur.hs),
        .vid_v_sync   (cur.vs),
        .vid_underflow(cur.uf),
        .test_en      (cur.te),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .vga_hs       (vga_hs),
        .vga_vs       (vga_vs),
        .vga_blank_n  (vga_blank_n),
        .vga_sync_n   (vga_sync_n),
        .vga_clk      (vga_clk),
        .frame_cnt    (frame_cnt),
        .underflow_cnt(underflow_cnt),
        .line_len     (line_len),
        .frame_lines  (frame_lines),
        .fill_active  (fill_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // input history: h1 = one cycle ago, h2 = two cycles ago
    vin_t h1 = '0;
    vin_t h2 = '0;
    int   nv = 0;
    bit   g_uf = 1'b0;
    bit   g_te = 1'b0;

    // reference model state
    vin_t mp;
    int   m_px, m_lines, m_flines, m_len, m_fcnt, m_ucnt, last_x;
    bit   m_seen_low, m_real, m_fill;
    logic [23:0] cap [640];
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
                              24'h00FF00, 24'hFF00FF, 24'hFF0000,
                              24'h0000FF, 24'h000000};

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mp = '0;
        m_px = 0; m_lines = 0; m_flines = 0; m_len = 0;
        m_fcnt = 0; m_ucnt = 0; last_x = -1;
        m_seen_low = 0; m_real = 0; m_fill = 0;
    endtask

    // Processes the input that entered two cycles ago and yields the
    // video outputs expected now; status fields are left in m_*.
    task automatic model_step(input vin_t v, output logic [23:0] er,
                              output bit eb, output bit eh, output bit ev);
        bit rise, fall, fs, ue;
        rise = v.dv && !mp.dv;
        fall = mp.dv && !v.dv;
        fs   = v.vs && !mp.vs;
        ue   = v.uf && !mp.uf;
        if (rise) begin
            m_real = m_seen_low;
            m_px = 1;
        end else if (v.dv) begin
            m_px++;
        end
        if (fs) begin
            m_flines = m_lines;
            m_lines = 0;
            m_fcnt = (m_fcnt + 1) % 65536;
        end
        if (fall) begin
            if (m_real) begin
                m_len = imin(m_px, 4095);
                if (!fs) m_lines = imin(m_lines + 1, 2047);
            end
            m_real = 0;
        end
        if (!v.dv) m_seen_low = 1;
        if (ue) begin
            m_ucnt = imin(m_ucnt + 1, 65535);
            m_fill = 1;
        end else if (fs) begin
            m_fill = 0;
        end
        eb = v.dv;
        eh = ~v.hs;
        ev = ~v.vs;
        if (!v.dv) er = 24'h0;
        else if (m_fill) er = FILL;
        else if (v.te) er = bars[imin((m_px - 1) / BW, 7)];
        else er = v.d[23:0];
        last_x = v.dv ? m_px - 1 : -1;
        mp = v;
    endtask

    task automatic check_cycle();
        logic [23:0] er;
        bit eb, eh, ev;
        if (nv >= 2) begin
            model_step(h2, er, eb, eh, ev);
        end else begin
            er = 24'h0; eb = 0; eh = 1; ev = 1;
            last_x = -1;
        end
        chk("cyc_video",
            64'({vga_r, vga_g, vga_b, vga_blank_n, vga_hs, vga_vs, vga_sync_n}),
            64'({er, eb, eh, ev, 1'b0}));
        chk("cyc_status",
            64'({frame_cnt, underflow_cnt, line_len, frame_lines, fill_active}),
            64'({16'(m_fcnt), 16'(m_ucnt), 12'(m_len), 11'(m_flines), m_fill}));
        if (last_x >= 0 && last_x < 640)
            cap[last_x] = {vga_r, vga_g, vga_b};
    endtask

    task automatic tick(input vin_t v);
        @(negedge clk);
        check_cycle();
        cur = v;
        h2 = h1;
        h1 = v;
        if (nv < 2) nv++;
    endtask

    task automatic idle(input int n);
        vin_t v;
        v = '0; v.uf = g_uf; v.te = g_te;
        repeat (n) tick(v);
    endtask

    task automatic do_reset(input vin_t v);
        @(negedge clk);
        rst = 1'b1;
        cur = v;
        repeat (3) @(negedge clk);
        model_reset();
        rst = 1'b0;
        cur = v;
        h1 = v;
        h2 = '0;
        nv = 1;
    endtask

    task automatic line(input int w, input logic [31:0] d, input bit rnd);
        vin_t v;
        v = '0; v.uf = g_uf; v.te = g_te;
        v.hs = 1; repeat (2) tick(v);
        v.hs = 0; repeat (2) tick(v);
        v.dv = 1;
        for (int i = 0; i < w; i++) begin
            v.d = rnd ? $urandom : d;
            tick(v);
        end
        v.dv = 0; repeat (2) tick(v);
    endtask

    task automatic vsync();
        vin_t v;
        v = '0; v.uf = g_uf; v.te = g_te;
        v.vs = 1; repeat (3) tick(v);
        v.vs = 0; repeat (2) tick(v);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        line_vec_t lv [5];
        bar_vec_t  bv [16];
        vin_t v;

        lv[0] = '{64,   1'b0, 32'hFF123456, 12'd64,   24'h123456};
        lv[1] = '{1,    1'b0, 32'h00ABCDEF, 12'd1,    24'hABCDEF};
        lv[2] = '{100,  1'b1, 32'h00000000, 12'd100,  24'hFFFFFF};
        lv[3] = '{5000, 1'b0, 32'h00112233, 12'd4095, 24'h112233};
        lv[4] = '{7,    1'b0, 32'h00FEDCBA, 12'd7,    24'hFEDCBA};
        for (int b = 0; b < 8; b++) begin
            bv[2*b]   = '{b * 80,      bars[b]};
            bv[2*b+1] = '{b * 80 + 79, bars[b]};
        end

        // reset and idle
        do_reset('0);
        idle(4);
        chk("rst_rgb", 64'({vga_r, vga_g, vga_b}), 64'h0);
        chk("rst_syncs", 64'({vga_hs, vga_vs, vga_blank_n, vga_sync_n}), 64'b1100);
        chk("rst_cnts", 64'({frame_cnt, underflow_cnt, line_len}), 64'h0);
        chk("rst_fill", 64'({frame_lines, fill_active}), 64'h0);
        chk("vga_clk", 64'(vga_clk), 64'(clk));

        // two-cycle latency of a single pixel
        v = '0; v.dv = 1; v.d = 32'h00123456;
        tick(v);
        idle(1);
        chk("lat1_blank", 64'(vga_blank_n), 64'h0);
        idle(1);
        chk("lat2_rgb", 64'({vga_r, vga_g, vga_b}), 64'h123456);
        chk("lat2_blank", 64'(vga_blank_n), 64'h1);
        idle(3);

        // two frames of 64x48
        vsync();
        for (int i = 0; i < 48; i++) line(64, 32'h00123456, 0);
        vsync();
        idle(3);
        chk("frm_lines", 64'(frame_lines), 64'd48);
        chk("frm_cnt", 64'(frame_cnt), 64'd2);
        chk("frm_len", 64'(line_len), 64'd64);

        // line table
        for (int i = 0; i < 5; i++) begin
            g_te = lv[i].te;
            line(lv[i].w, lv[i].d, 0);
            g_te = 0;
            idle(3);
            chk($sformatf("tbl_len%0d", i), 64'(line_len), 64'(lv[i].exp_len));
            chk($sformatf("tbl_px0_%0d", i), 64'(cap[0]), 64'(lv[i].exp_px0));
        end

        // colour bars over one 640 pixel line
        g_te = 1;
        line(640, 32'h00123456, 0);
        g_te = 0;
        idle(3);
        chk("bar_len", 64'(line_len), 64'd640);
        for (int i = 0; i < 16; i++)
            chk($sformatf("bar_x%0d", bv[i].x), 64'(cap[bv[i].x]), 64'(bv[i].rgb));

        // underflow pulse mid-frame
        vsync();
        line(32, 32'h00123456, 0);
        g_uf = 1; idle(1);
        g_uf = 0; idle(3);
        chk("uf_cnt1", 64'(underflow_cnt), 64'd1);
        chk("uf_fill1", 64'(fill_active), 64'd1);
        line(32, 32'h00123456, 0);
        chk("uf_px0", 64'(cap[0]), 64'(FILL));
        chk("uf_px31", 64'(cap[31]), 64'(FILL));
        vsync();
        idle(2);
        chk("uf_clr", 64'(fill_active), 64'd0);
        line(32, 32'h00123456, 0);
        chk("uf_resume", 64'(cap[0]), 64'h123456);

        // underflow edge together with FS, then held high across next FS
        g_uf = 1;
        vsync();
        line(16, 32'h00123456, 0);
        chk("coin_fill", 64'(fill_active), 64'd1);
        chk("coin_cnt", 64'(underflow_cnt), 64'd2);
        chk("coin_px", 64'(cap[0]), 64'(FILL));
        vsync();
        idle(3);
        chk("held_fill", 64'(fill_active), 64'd0);
        chk("held_cnt", 64'(underflow_cnt), 64'd2);
        g_uf = 0;
        idle(2);

        // reset in the middle of a line
        v = '0; v.dv = 1; v.d = 32'h00445566;
        do_reset(v);
        repeat (10) tick(v);
        idle(3);
        chk("rml_len", 64'(line_len), 64'd0);
        for (int i = 0; i < 3; i++) line(20, 32'h00445566, 1);
        vsync();
        idle(3);
        chk("rml_flines", 64'(frame_lines), 64'd3);
        chk("rml_len2", 64'(line_len), 64'd20);
        chk("rml_fcnt", 64'(frame_cnt), 64'd1);

        // line counter saturation
        for (int i = 0; i < 2050; i++) line(1, 32'h00010203, 0);
        vsync();
        idle(3);
        chk("lines_sat", 64'(frame_lines), 64'd2047);

        // underflow counter saturation, preloaded near the top
        force dut.ucnt_q = 16'hFFFD;
        m_ucnt = 65533;
        idle(2);
        release dut.ucnt_q;
        for (int i = 0; i < 4; i++) begin
            g_uf = 1; idle(1);
            g_uf = 0; idle(1);
        end
        idle(3);
        chk("uf_sat", 64'(underflow_cnt), 64'hFFFF);

        // randomized traffic against the model
        v = '0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 7) == 0)  v.dv = ~v.dv;
            if ($urandom_range(0, 9) == 0)  v.hs = ~v.hs;
            if ($urandom_range(0, 49) == 0) v.vs = ~v.vs;
            if ($urandom_range(0, 29) == 0) v.uf = ~v.uf;
            if ($urandom_range(0, 19) == 0) v.te = ~v.te;
            v.d = $urandom;
            tick(v);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
